l2_tag_req_arbiter: RTL and testbench
=====================================

L2_TAG_REQ_ARBITER -- requirements
Module: l2_tag_req_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 20, tag width.
REQ-002 The block SHALL have parameter SET_W, default 8, set-index width.
REQ-003 The block SHALL have parameter WAY_W, default 3, way-index width.
REQ-004 The block SHALL have parameter TMO, default 15, maximum response wait in cycles.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 req0_valid/req0_ready  in/out  1/1  requester 0 lookup handshake.
REQ-008 req0_addr  in  TAG_W+SET_W  {tag, set} of requester 0.
REQ-009 req1_valid/req1_ready  in/out  1/1  requester 1 lookup handshake.
REQ-010 req1_addr  in  TAG_W+SET_W  {tag, set} of requester 1.
REQ-011 rsp0_valid/rsp1_valid  out  1/1  one-cycle response strobe to the owning requester.
REQ-012 rsp_way  out  WAY_W  returned way, qualified by rsp0_valid or rsp1_valid.
REQ-013 flush_req_valid/flush_req_ready  in/out  1/1  flush request handshake.
REQ-014 flush_done  out  1  one-cycle strobe when the bank completes a flush.
REQ-015 tag_in_valid/tag_in_ready, set_in_valid/set_in_ready  out/in  1 each  bank input channels.
REQ-016 tag_in_data  out  TAG_W; set_in_data  out  SET_W  registered bank inputs.
REQ-017 way_out_valid/way_out_ready  in/out  1/1; way_out_data  in  WAY_W  bank response.
REQ-018 flush_in_valid/flush_in_ready  out/in  1/1; flush_complete_valid/flush_complete_ready  in/out  1/1.
REQ-019 busy  out  1  high in every state except IDLE; tmo_err  out  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_RSP, FLUSH_ISSUE, FLUSH_WAIT; at most one lookup or one flush outstanding at the bank.
REQ-021 IDLE priority SHALL be: pending flush when the flush-age counter reaches 4, else lookups in round-robin order, else flush.
REQ-022 Round-robin SHALL use a last-grant bit, toggled on each lookup grant, so requester 1 is granted first after reset on a tie.
REQ-023 req*_ready SHALL be high only in IDLE for the granted requester, combinationally; addr, tag/set and owner SHALL latch on valid&&ready.
REQ-024 ISSUE SHALL hold tag_in_valid and set_in_valid high together; each drops independently on its own ready, and the FSM enters WAIT_RSP when both have handshaken.
REQ-025 way_out_ready SHALL be constant 1; on way_out_valid in WAIT_RSP the owner's rsp strobe SHALL assert the next cycle with rsp_way=way_out_data, then return to IDLE.
REQ-026 Lookup latency SHALL be grant to tag/set_in_valid = 1 cycle and way_out_valid to rsp strobe = 1 cycle.
REQ-027 A WAIT_RSP counter SHALL saturate at TMO; on reaching TMO, tmo_err SHALL set, the owner SHALL get rsp with rsp_way=0, and the FSM SHALL return to IDLE.
REQ-028 A way_out_valid outside WAIT_RSP SHALL be ignored and SHALL set tmo_err.
REQ-029 flush_req_ready SHALL be high only in IDLE on a flush grant; FLUSH_ISSUE SHALL hold flush_in_valid until flush_in_ready, then go to FLUSH_WAIT.
REQ-030 flush_complete_ready SHALL be 1 in FLUSH_WAIT; flush_complete_valid there SHALL produce flush_done next cycle and return to IDLE.
REQ-031 The 3-bit flush-age counter SHALL count IDLE lookup grants while flush_req_valid is high, clear on flush grant, and saturate at 4.
REQ-032 Simultaneous req0, req1 and flush_req with age<4 SHALL grant a lookup; the losing valids SHALL stay pending without being dropped.
REQ-033 tmo_err SHALL clear only by reset.

Reset
REQ-034 rst low SHALL asynchronously force IDLE, clear all counters and the last-grant bit, and drive every valid, strobe, busy and tmo_err low, with data outputs 0.
REQ-035 Reset mid-transaction SHALL abandon it; a later stray way_out_valid or flush_complete_valid SHALL follow REQ-028 or be ignored.

Verification
REQ-036 req0 addr={0x12345,0x0A}, bank responds way 5 after 3 cycles -> tag_in_data=0x12345, set_in_data=0x0A, rsp0_valid with rsp_way=5 exactly 1 cycle after way_out_valid.
REQ-037 req0 and req1 both valid continuously from reset -> grants alternate 1,0,1,0 and no requester is ready twice in a row.
REQ-038 flush_req held with both requesters saturating -> flush granted after exactly 4 lookup grants; flush_done 1 cycle after flush_complete_valid.
REQ-039 set_in_ready 3 cycles after tag_in_ready -> tag_in_valid drops first, and WAIT_RSP is entered only after set handshake.
REQ-040 No way_out_valid for TMO=15 cycles -> tmo_err=1, rsp strobe with rsp_way=0, busy=0 the following cycle.
REQ-041 rst asserted during WAIT_RSP -> all outputs 0 immediately, no rsp strobe after release.

Source files
------------

// File: rtl/l2_tag_req_arbiter.sv
// Arbitrates two tag-lookup requesters and a flush requester onto one L2 tag bank,
// keeping at most one lookup or one flush outstanding at the bank.
module l2_tag_req_arbiter #(
  parameter int TAG_W = 20,
  parameter int SET_W = 8,
  parameter int WAY_W = 3,
  parameter int TMO   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [TAG_W+SET_W-1:0] req0_addr,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [TAG_W+SET_W-1:0] req1_addr,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [WAY_W-1:0]       rsp_way,
  input  logic                   flush_req_valid,
  output logic                   flush_req_ready,
  output logic                   flush_done,
  output logic                   tag_in_valid,
  input  logic                   tag_in_ready,
  output logic [TAG_W-1:0]       tag_in_data,
  output logic                   set_in_valid,
  input  logic                   set_in_ready,
  output logic [SET_W-1:0]       set_in_data,
  input  logic                   way_out_valid,
  output logic                   way_out_ready,
  input  logic [WAY_W-1:0]       way_out_data,
  output logic                   flush_in_valid,
  input  logic                   flush_in_ready,
  input  logic                   flush_complete_valid,
  output logic                   flush_complete_ready,
  output logic                   busy,
  output logic                   tmo_err
);

  localparam int CNT_W = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    FLUSH_ISSUE,
    FLUSH_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [2:0]         age_q, age_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               tag_pend_q, tag_pend_d;
  logic               set_pend_q, set_pend_d;
  logic               rsp0_q, rsp0_d;
  logic               rsp1_q, rsp1_d;
  logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
  logic               flush_done_q, flush_done_d;
  logic               tmo_q, tmo_d;
  logic               grant0, grant1, flush_gnt;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    age_d        = age_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    set_d        = set_q;
    tag_pend_d   = tag_pend_q;
    set_pend_d   = set_pend_q;
    rsp0_d       = 1'b0;
    rsp1_d       = 1'b0;
    rsp_way_d    = '0;
    flush_done_d = 1'b0;
    tmo_d        = tmo_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    flush_gnt    = 1'b0;
    cnt_inc      = (cnt_q == CNT_W'(TMO)) ? cnt_q : cnt_q + 1'b1;

    // A bank response with no lookup outstanding is a protocol error.
    if (way_out_valid && (state_q != WAIT_RSP)) tmo_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // last_q == 0 favours requester 1, so it wins the first tie after reset.
        if (flush_req_valid && (age_q == 3'd4)) begin
          flush_gnt = 1'b1;
        end else if (req0_valid || req1_valid) begin
          if (req1_valid && (!last_q || !req0_valid)) grant1 = 1'b1;
          else                                        grant0 = 1'b1;
        end else if (flush_req_valid) begin
          flush_gnt = 1'b1;
        end

        if (grant0 || grant1) begin
          owner_d    = grant1;
          tag_d      = grant1 ? req1_addr[TAG_W+SET_W-1:SET_W] : req0_addr[TAG_W+SET_W-1:SET_W];
          set_d      = grant1 ? req1_addr[SET_W-1:0] : req0_addr[SET_W-1:0];
          last_d     = ~last_q;
          tag_pend_d = 1'b1;
          set_pend_d = 1'b1;
          state_d    = ISSUE;
          if (flush_req_valid && (age_q != 3'd4)) age_d = age_q + 3'd1;
        end else if (flush_gnt) begin
          age_d   = '0;
          state_d = FLUSH_ISSUE;
        end
      end

      ISSUE: begin
        if (tag_in_ready) tag_pend_d = 1'b0;
        if (set_in_ready) set_pend_d = 1'b0;
        if ((!tag_pend_q || tag_in_ready) && (!set_pend_q || set_in_ready)) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (way_out_valid) begin
          rsp0_d    = ~owner_q;
          rsp1_d    = owner_q;
          rsp_way_d = way_out_data;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_inc == CNT_W'(TMO)) begin
          rsp0_d  = ~owner_q;
          rsp1_d  = owner_q;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      FLUSH_ISSUE: begin
        if (flush_in_ready) state_d = FLUSH_WAIT;
      end

      FLUSH_WAIT: begin
        if (flush_complete_valid) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      owner_q      <= 1'b0;
      age_q        <= '0;
      cnt_q        <= '0;
      tag_q        <= '0;
      set_q        <= '0;
      tag_pend_q   <= 1'b0;
      set_pend_q   <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      rsp_way_q    <= '0;
      flush_done_q <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      age_q        <= age_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      tag_pend_q   <= tag_pend_d;
      set_pend_q   <= set_pend_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      rsp_way_q    <= rsp_way_d;
      flush_done_q <= flush_done_d;
      tmo_q        <= tmo_d;
    end
  end

  // Readies are combinational grants; gating with rst keeps them low during reset.
  assign req0_ready           = rst & grant0;
  assign req1_ready           = rst & grant1;
  assign flush_req_ready      = rst & flush_gnt;
  assign tag_in_valid         = tag_pend_q;
  assign set_in_valid         = set_pend_q;
  assign tag_in_data          = tag_q;
  assign set_in_data          = set_q;
  assign way_out_ready        = 1'b1;
  assign rsp0_valid           = rsp0_q;
  assign rsp1_valid           = rsp1_q;
  assign rsp_way              = rsp_way_q;
  assign flush_in_valid       = (state_q == FLUSH_ISSUE);
  assign flush_complete_ready = (state_q == FLUSH_WAIT);
  assign flush_done           = flush_done_q;
  assign busy                 = (state_q != IDLE);
  assign tmo_err              = tmo_q;

endmodule

// File: tb/tb_l2_tag_req_arbiter.sv
// Scoreboard bench for l2_tag_req_arbiter: expected responses are queued when the
// bank stimulus is driven and retired by a monitor when a response strobe appears.
module tb_l2_tag_req_arbiter;

  localparam int TAG_W = 20;
  localparam int SET_W = 8;
  localparam int WAY_W = 3;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [TAG_W+SET_W-1:0] req0_addr, req1_addr;
  logic rsp0_valid, rsp1_valid;
  logic [WAY_W-1:0] rsp_way;
  logic flush_req_valid, flush_req_ready, flush_done;
  logic tag_in_valid, tag_in_ready, set_in_valid, set_in_ready;
  logic [TAG_W-1:0] tag_in_data;
  logic [SET_W-1:0] set_in_data;
  logic way_out_valid, way_out_ready;
  logic [WAY_W-1:0] way_out_data;
  logic flush_in_valid, flush_in_ready, flush_complete_valid, flush_complete_ready;
  logic busy, tmo_err;

  typedef struct {
    logic             owner;
    logic [WAY_W-1:0] way;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  l2_tag_req_arbiter #(.TAG_W(TAG_W), .SET_W(SET_W), .WAY_W(WAY_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_way(rsp_way),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready), .flush_done(flush_done),
    .tag_in_valid(tag_in_valid), .tag_in_ready(tag_in_ready), .tag_in_data(tag_in_data),
    .set_in_valid(set_in_valid), .set_in_ready(set_in_ready), .set_in_data(set_in_data),
    .way_out_valid(way_out_valid), .way_out_ready(way_out_ready), .way_out_data(way_out_data),
    .flush_in_valid(flush_in_valid), .flush_in_ready(flush_in_ready),
    .flush_complete_valid(flush_complete_valid), .flush_complete_ready(flush_complete_ready),
    .busy(busy), .tmo_err(tmo_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every strobe must retire the oldest expected response.
  always @(negedge clk) begin
    if (rst && (rsp0_valid || rsp1_valid)) begin
      if (rsp0_valid && rsp1_valid) begin
        check("rsp_both", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
      end else if (sb.size() == 0) begin
        check("rsp_unexp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e.owner});
        check("rsp_way", {29'd0, rsp_way}, {29'd0, e.way});
      end
    end
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; flush_req_valid = 1'b0;
    tag_in_ready = 1'b0; set_in_ready = 1'b0;
    way_out_valid = 1'b0; way_out_data = '0;
    flush_in_ready = 1'b0; flush_complete_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One lookup round with both requesters held valid; called at the IDLE negedge.
  task automatic rr_round(input logic g);
    logic [WAY_W-1:0] w;
    logic [TAG_W+SET_W-1:0] a;
    w = g ? 3'd6 : 3'd1;
    a = g ? req1_addr : req0_addr;
    #1;
    check("rr_rdy1", {31'd0, req1_ready}, {31'd0, g});
    check("rr_rdy0", {31'd0, req0_ready}, {31'd0, ~g});
    check("rr_frdy", {31'd0, flush_req_ready}, 32'd0);
    @(negedge clk);
    check("rr_tag", {12'd0, tag_in_data}, {12'd0, a[TAG_W+SET_W-1:SET_W]});
    check("rr_rdy_issue", {30'd0, req1_ready, req0_ready}, 32'd0);
    tag_in_ready = 1'b1; set_in_ready = 1'b1;
    @(negedge clk);
    tag_in_ready = 1'b0; set_in_ready = 1'b0;
    way_out_valid = 1'b1; way_out_data = w;
    sb.push_back('{owner: g, way: w});
    @(negedge clk);
    way_out_valid = 1'b0;
  endtask

  initial begin
    logic g;
    rst = 1'b0;
    clear_inputs();
    req0_addr = '0; req1_addr = '0;

    // Reset state, with a requester already asserting valid.
    req0_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_ctl", {20'd0, busy, tmo_err, tag_in_valid, set_in_valid, rsp0_valid, rsp1_valid,
                      flush_in_valid, flush_done, flush_complete_ready, req0_ready, req1_ready,
                      flush_req_ready}, 32'd0);
    check("rst_data", {1'b0, tag_in_data, set_in_data, rsp_way}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Single lookup from requester 0, bank answers way 5.
    req0_addr = {20'h12345, 8'h0A}; req0_valid = 1'b1;
    #1 check("t36_rdy", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t36_data", {4'd0, tag_in_data, set_in_data}, {4'd0, 20'h12345, 8'h0A});
    check("t36_vld", {30'd0, tag_in_valid, set_in_valid}, 32'd3);
    check("t36_busy", {31'd0, busy}, 32'd1);
    tag_in_ready = 1'b1; set_in_ready = 1'b1;
    @(negedge clk);
    tag_in_ready = 1'b0; set_in_ready = 1'b0;
    check("t36_vld_off", {30'd0, tag_in_valid, set_in_valid}, 32'd0);
    repeat (2) @(negedge clk);
    way_out_valid = 1'b1; way_out_data = 3'd5;
    sb.push_back('{owner: 1'b0, way: 3'd5});
    @(negedge clk);
    way_out_valid = 1'b0;
    check("t36_rsp0", {31'd0, rsp0_valid}, 32'd1);
    check("t36_way", {29'd0, rsp_way}, 32'd5);
    check("t36_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t36_strobe1", {31'd0, rsp0_valid}, 32'd0);

    // Both requesters continuously valid from reset: 1,0,1,0.
    do_reset();
    req0_addr = {20'hAAAAA, 8'h11}; req1_addr = {20'h55555, 8'h22};
    req0_valid = 1'b1; req1_valid = 1'b1;
    g = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      rr_round(g);
      g = ~g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Flush held against saturating lookups: granted after exactly 4 lookups.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; flush_req_valid = 1'b1;
    g = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      rr_round(g);
      g = ~g;
    end
    #1;
    check("t38_frdy", {31'd0, flush_req_ready}, 32'd1);
    check("t38_lrdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    check("t38_fin_vld", {31'd0, flush_in_valid}, 32'd1);
    @(negedge clk);
    check("t38_fin_hold", {31'd0, flush_in_valid}, 32'd1);
    flush_in_ready = 1'b1; flush_req_valid = 1'b0;
    @(negedge clk);
    flush_in_ready = 1'b0;
    check("t38_fwait", {30'd0, flush_in_valid, flush_complete_ready}, 32'd1);
    check("t38_done_early", {31'd0, flush_done}, 32'd0);
    flush_complete_valid = 1'b1;
    @(negedge clk);
    flush_complete_valid = 1'b0;
    check("t38_done", {31'd0, flush_done}, 32'd1);
    #1 check("t38_pending_rdy1", {30'd0, req1_ready, req0_ready}, 32'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("t38_done_strobe", {31'd0, flush_done}, 32'd0);

    // set_in_ready three cycles after tag_in_ready.
    req0_addr = {20'h0BEEF, 8'h33}; req0_valid = 1'b1;
    #1 check("t39_rdy", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; tag_in_ready = 1'b1;
    @(negedge clk);
    tag_in_ready = 1'b0;
    check("t39_split_a", {30'd0, tag_in_valid, set_in_valid}, 32'd1);
    @(negedge clk);
    check("t39_split_b", {30'd0, tag_in_valid, set_in_valid}, 32'd1);
    @(negedge clk);
    check("t39_split_c", {30'd0, tag_in_valid, set_in_valid}, 32'd1);
    set_in_ready = 1'b1;
    @(negedge clk);
    set_in_ready = 1'b0;
    check("t39_vld_off", {30'd0, tag_in_valid, set_in_valid}, 32'd0);
    way_out_valid = 1'b1; way_out_data = 3'd3;
    sb.push_back('{owner: 1'b0, way: 3'd3});
    @(negedge clk);
    way_out_valid = 1'b0;
    check("t39_rsp0", {31'd0, rsp0_valid}, 32'd1);
    check("t39_tmo", {31'd0, tmo_err}, 32'd0);

    // Response timeout on a requester 1 lookup.
    req1_addr = {20'h00777, 8'h44}; req1_valid = 1'b1;
    #1 check("t40_rdy", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0; tag_in_ready = 1'b1; set_in_ready = 1'b1;
    @(negedge clk);
    tag_in_ready = 1'b0; set_in_ready = 1'b0;
    sb.push_back('{owner: 1'b1, way: 3'd0});
    repeat (TMO - 1) @(negedge clk);
    check("t40_pre", {29'd0, busy, tmo_err, rsp1_valid}, 32'd4);
    @(negedge clk);
    check("t40_tmo", {31'd0, tmo_err}, 32'd1);
    check("t40_rsp1", {31'd0, rsp1_valid}, 32'd1);
    check("t40_way0", {29'd0, rsp_way}, 32'd0);
    check("t40_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t40_sticky", {31'd0, tmo_err}, 32'd1);

    // Reset during WAIT_RSP, then stray bank strobes.
    do_reset();
    check("t41_tmo_clr", {31'd0, tmo_err}, 32'd0);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; tag_in_ready = 1'b1; set_in_ready = 1'b1;
    @(negedge clk);
    tag_in_ready = 1'b0; set_in_ready = 1'b0;
    @(negedge clk);
    check("t41_busy_wait", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1 check("t41_async", {23'd0, busy, tmo_err, tag_in_valid, set_in_valid, rsp0_valid,
                           rsp1_valid, flush_in_valid, flush_done, flush_complete_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t41_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    way_out_valid = 1'b1; way_out_data = 3'd7;
    @(negedge clk);
    way_out_valid = 1'b0;
    check("t41_stray_tmo", {31'd0, tmo_err}, 32'd1);
    check("t41_stray_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    flush_complete_valid = 1'b1;
    @(negedge clk);
    flush_complete_valid = 1'b0;
    check("t41_stray_flush", {30'd0, flush_done, busy}, 32'd0);

    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
